// File: rtl/axi_default_param_pkg.sv
// Default AXI and grid-flit types shared by the grid SNI/MNI pair.
// Latency: n/a (types, widths and shared enums only).
// Backpressure: n/a.
package axi_default_param_pkg;

   localparam int ID_W      = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int STRB_W    = DATA_W / 8;
   localparam int GRID_ID_W = 4;

   typedef logic [ID_W-1:0]      id_t;
   typedef logic [GRID_ID_W-1:0] grid_id_t;

   typedef struct packed {
      id_t               id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } aw_chan_t;

   typedef aw_chan_t ar_chan_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } w_chan_t;

   typedef struct packed {
      id_t        id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      id_t               id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } mni_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      r_chan_t r;
      logic    r_valid;
   } mni_resp_t;

   // Grid flits: routing header followed by the AXI payload.
   typedef struct packed { grid_id_t src; grid_id_t dst; aw_chan_t payload; } grid_aw_chan_t;
   typedef struct packed { grid_id_t src; grid_id_t dst; w_chan_t  payload; } grid_w_chan_t;
   typedef struct packed { grid_id_t src; grid_id_t dst; b_chan_t  payload; } grid_b_chan_t;
   typedef struct packed { grid_id_t src; grid_id_t dst; ar_chan_t payload; } grid_ar_chan_t;
   typedef struct packed { grid_id_t src; grid_id_t dst; r_chan_t  payload; } grid_r_chan_t;

   // One outstanding transaction: who sent it and with which AXI ID.
   typedef struct packed {
      grid_id_t src;
      id_t      id;
   } txn_entry_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_DATA = 1'b1
   } w_state_e;

endpackage

// File: rtl/axi_grid_mni_txn_table.sv
// Outstanding-transaction table: slot index doubles as the local AXI ID.
// Latency: alloc/free take effect at the next edge; lookup is combinational.
// Backpressure: alloc_gnt_o low when every slot is valid; it never depends on alloc_req_i.
// Ports: alloc_req_i/alloc_entry_i -> alloc_gnt_o/alloc_idx_o (lowest free slot),
//        lookup_id_i -> lookup_entry_o/lookup_valid_o, free_i/free_idx_i clears a slot.
module axi_grid_mni_txn_table
   import axi_default_param_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter type entry_t = txn_entry_t,
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             alloc_req_i,
   input  entry_t           alloc_entry_i,
   output logic             alloc_gnt_o,
   output logic [IDX_W-1:0] alloc_idx_o,
   input  id_t              lookup_id_i,
   output entry_t           lookup_entry_o,
   output logic             lookup_valid_o,
   input  logic             free_i,
   input  logic [IDX_W-1:0] free_idx_i
);

   logic [DEPTH-1:0] valid_q;
   entry_t           entry_q [DEPTH];
   logic [IDX_W-1:0] lookup_idx;

   // Priority encode from the top down so the lowest free slot wins.
   always_comb begin
      alloc_gnt_o = ~&valid_q;
      alloc_idx_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_idx_o = IDX_W'(i);
      end
   end

   // IDs beyond the table depth can never be valid.
   assign lookup_idx     = lookup_id_i[IDX_W-1:0];
   assign lookup_valid_o = (int'(lookup_id_i) < DEPTH) && valid_q[lookup_idx];
   assign lookup_entry_o = entry_q[lookup_idx];

   // A freed slot is always valid and an allocated slot always free, so the
   // two writes below never target the same index.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         valid_q <= '0;
      end else begin
         if (free_i) valid_q[free_idx_i] <= 1'b0;
         if (alloc_req_i && alloc_gnt_o) begin
            valid_q[alloc_idx_o] <= 1'b1;
            entry_q[alloc_idx_o] <= alloc_entry_i;
         end
      end
   end

endmodule

// File: rtl/axi_grid_mni.sv
// Grid manager NI: grid AW/W/AR flits -> local AXI with remapped IDs, B/R back to origin.
// Latency: zero-cycle both directions; only tables, write FSM and w_src_q hold state.
// Backpressure: grid readies follow subordinate readies, gated by table space and write-source lock.
// Ports: clk_i/srst_i; req_o/resp_i to the subordinate; grid_{aw,w,ar}_i in, grid_{b,r}_o out,
//        each with valid/ready; err_o pulses on a response to an unused ID.
module axi_grid_mni #(
   parameter type req_t          = axi_default_param_pkg::mni_req_t,
   parameter type resp_t         = axi_default_param_pkg::mni_resp_t,
   parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
   parameter type grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
   parameter type grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
   parameter type grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
   parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
   parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
   parameter grid_id_t NI_ID     = '0,
   parameter int  MAX_W_TXN      = 8,
   parameter int  MAX_R_TXN      = 8
) (
   input  logic          clk_i,
   input  logic          srst_i,
   output req_t          req_o,
   input  resp_t         resp_i,
   input  grid_aw_chan_t grid_aw_i,
   input  logic          grid_aw_valid_i,
   output logic          grid_aw_ready_o,
   input  grid_w_chan_t  grid_w_i,
   input  logic          grid_w_valid_i,
   output logic          grid_w_ready_o,
   input  grid_ar_chan_t grid_ar_i,
   input  logic          grid_ar_valid_i,
   output logic          grid_ar_ready_o,
   output grid_b_chan_t  grid_b_o,
   output logic          grid_b_valid_o,
   input  logic          grid_b_ready_i,
   output grid_r_chan_t  grid_r_o,
   output logic          grid_r_valid_o,
   input  logic          grid_r_ready_i,
   output logic          err_o
);

   import axi_default_param_pkg::*;

   localparam int WIDX_W = (MAX_W_TXN > 1) ? $clog2(MAX_W_TXN) : 1;
   localparam int RIDX_W = (MAX_R_TXN > 1) ? $clog2(MAX_R_TXN) : 1;

   w_state_e          state_q, state_d;
   grid_id_t          w_src_q;
   logic              aw_open, w_open, ar_open;
   logic              aw_hs, w_hs, ar_hs;
   logic              w_gnt, r_gnt;
   logic [WIDX_W-1:0] w_idx;
   logic [RIDX_W-1:0] r_idx;
   txn_entry_t        b_ent, r_ent;
   logic              b_hit, r_hit;
   logic              b_free, r_free;

   axi_grid_mni_txn_table #(.DEPTH(MAX_W_TXN), .entry_t(txn_entry_t)) u_w_table (
      .clk_i          (clk_i),
      .srst_i         (srst_i),
      .alloc_req_i    (aw_hs),
      .alloc_entry_i  (txn_entry_t'{src: grid_aw_i.src, id: grid_aw_i.payload.id}),
      .alloc_gnt_o    (w_gnt),
      .alloc_idx_o    (w_idx),
      .lookup_id_i    (resp_i.b.id),
      .lookup_entry_o (b_ent),
      .lookup_valid_o (b_hit),
      .free_i         (b_free),
      .free_idx_i     (resp_i.b.id[WIDX_W-1:0])
   );

   axi_grid_mni_txn_table #(.DEPTH(MAX_R_TXN), .entry_t(txn_entry_t)) u_r_table (
      .clk_i          (clk_i),
      .srst_i         (srst_i),
      .alloc_req_i    (ar_hs),
      .alloc_entry_i  (txn_entry_t'{src: grid_ar_i.src, id: grid_ar_i.payload.id}),
      .alloc_gnt_o    (r_gnt),
      .alloc_idx_o    (r_idx),
      .lookup_id_i    (resp_i.r.id),
      .lookup_entry_o (r_ent),
      .lookup_valid_o (r_hit),
      .free_i         (r_free),
      .free_idx_i     (resp_i.r.id[RIDX_W-1:0])
   );

   // Write FSM: state register.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= W_IDLE;
         w_src_q <= '0;
      end else begin
         state_q <= state_d;
         if (aw_hs) w_src_q <= grid_aw_i.src;
      end
   end

   // Write FSM: next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         W_IDLE:  if (aw_hs) state_d = W_DATA;
         W_DATA:  if (w_hs && grid_w_i.payload.last) state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end

   // Write FSM: outputs. W is only open to the source that owns the current burst,
   // so interleaved data from other nodes waits at the grid.
   always_comb begin
      aw_open = !srst_i && (state_q == W_IDLE) && w_gnt;
      w_open  = !srst_i && (state_q == W_DATA) && (grid_w_i.src == w_src_q);
   end

   assign ar_open = !srst_i && r_gnt;
   assign aw_hs   = grid_aw_valid_i && grid_aw_ready_o;
   assign w_hs    = grid_w_valid_i && grid_w_ready_o;
   assign ar_hs   = grid_ar_valid_i && grid_ar_ready_o;
   assign b_free  = grid_b_valid_o && grid_b_ready_i;
   assign r_free  = grid_r_valid_o && grid_r_ready_i && resp_i.r.last;

   // Channel muxing. Responses to unknown IDs are sunk (ready forced high).
   always_comb begin
      req_o             = '0;
      req_o.aw          = grid_aw_i.payload;
      req_o.aw.id       = ID_W'(w_idx);
      req_o.aw_valid    = aw_open && grid_aw_valid_i;
      grid_aw_ready_o   = aw_open && resp_i.aw_ready;

      req_o.w           = grid_w_i.payload;
      req_o.w_valid     = w_open && grid_w_valid_i;
      grid_w_ready_o    = w_open && resp_i.w_ready;

      req_o.ar          = grid_ar_i.payload;
      req_o.ar.id       = ID_W'(r_idx);
      req_o.ar_valid    = ar_open && grid_ar_valid_i;
      grid_ar_ready_o   = ar_open && resp_i.ar_ready;

      grid_b_o            = '0;
      grid_b_o.src        = NI_ID;
      grid_b_o.dst        = b_ent.src;
      grid_b_o.payload    = resp_i.b;
      grid_b_o.payload.id = b_ent.id;
      grid_b_valid_o      = !srst_i && resp_i.b_valid && b_hit;
      req_o.b_ready       = !srst_i && (b_hit ? grid_b_ready_i : 1'b1);

      grid_r_o            = '0;
      grid_r_o.src        = NI_ID;
      grid_r_o.dst        = r_ent.src;
      grid_r_o.payload    = resp_i.r;
      grid_r_o.payload.id = r_ent.id;
      grid_r_valid_o      = !srst_i && resp_i.r_valid && r_hit;
      req_o.r_ready       = !srst_i && (r_hit ? grid_r_ready_i : 1'b1);

      err_o = !srst_i && ((resp_i.b_valid && !b_hit) || (resp_i.r_valid && !r_hit));
   end

endmodule

// File: tb/tb_axi_grid_mni.sv
// Directed bench for axi_grid_mni: reads, ID remap, write-source lock, full table, errors, reset.
// Latency: checks combinational outputs 2 time units after each rising edge.
// Backpressure: subordinate and grid sinks are always ready.
module tb_axi_grid_mni;
   import axi_default_param_pkg::*;

   logic          clk = 1'b0;
   logic          srst;
   mni_req_t      req;
   mni_resp_t     resp;
   grid_aw_chan_t gaw;
   logic          gaw_v, gaw_r;
   grid_w_chan_t  gw;
   logic          gw_v, gw_r;
   grid_ar_chan_t gar;
   logic          gar_v, gar_r;
   grid_b_chan_t  gb;
   logic          gb_v, gb_r;
   grid_r_chan_t  gr;
   logic          gr_v, gr_r;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi_grid_mni #(.NI_ID(4'h9)) dut (
      .clk_i           (clk),
      .srst_i          (srst),
      .req_o           (req),
      .resp_i          (resp),
      .grid_aw_i       (gaw),
      .grid_aw_valid_i (gaw_v),
      .grid_aw_ready_o (gaw_r),
      .grid_w_i        (gw),
      .grid_w_valid_i  (gw_v),
      .grid_w_ready_o  (gw_r),
      .grid_ar_i       (gar),
      .grid_ar_valid_i (gar_v),
      .grid_ar_ready_o (gar_r),
      .grid_b_o        (gb),
      .grid_b_valid_o  (gb_v),
      .grid_b_ready_i  (gb_r),
      .grid_r_o        (gr),
      .grid_r_valid_o  (gr_v),
      .grid_r_ready_i  (gr_r),
      .err_o           (err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ar(input logic v, input logic [3:0] s, input logic [3:0] id, input logic [7:0] len);
      gar = '0; gar.src = s; gar.dst = 4'h9; gar.payload.id = id; gar.payload.len = len; gar_v = v;
   endtask

   task automatic set_aw(input logic v, input logic [3:0] s, input logic [3:0] id);
      gaw = '0; gaw.src = s; gaw.dst = 4'h9; gaw.payload.id = id; gaw_v = v;
   endtask

   task automatic set_w(input logic v, input logic [3:0] s, input logic [31:0] d, input logic last);
      gw = '0; gw.src = s; gw.dst = 4'h9; gw.payload.data = d; gw.payload.last = last; gw_v = v;
   endtask

   task automatic set_r(input logic v, input logic [3:0] id, input logic [31:0] d, input logic last);
      resp.r = '0; resp.r.id = id; resp.r.data = d; resp.r.last = last; resp.r_valid = v;
   endtask

   task automatic set_b(input logic v, input logic [3:0] id);
      resp.b = '0; resp.b.id = id; resp.b_valid = v;
   endtask

   initial begin
      srst = 1'b1;
      resp = '0;
      resp.aw_ready = 1'b1; resp.w_ready = 1'b1; resp.ar_ready = 1'b1;
      gb_r = 1'b1; gr_r = 1'b1;
      set_ar(0, 0, 0, 0); set_aw(0, 0, 0); set_w(0, 0, 0, 0);
      repeat (2) step();
      srst = 1'b0;
      #1;
      chk("rst_aw_vld", req.aw_valid, 0);
      chk("rst_w_vld", req.w_valid, 0);
      chk("rst_ar_vld", req.ar_valid, 0);
      chk("rst_b_vld", gb_v, 0);
      chk("rst_r_vld", gr_v, 0);
      chk("rst_err", err, 0);
      chk("rst_ar_rdy", gar_r, 1);

      // Single read: src=3 id=5 len=3 -> AXI id 0, four beats back to node 3.
      step();
      set_ar(1, 3, 5, 3);
      #1;
      chk("rd_ar_vld", req.ar_valid, 1);
      chk("rd_ar_id", req.ar.id, 0);
      chk("rd_ar_len", req.ar.len, 3);
      chk("rd_ar_rdy", gar_r, 1);
      step();
      set_ar(0, 0, 0, 0);
      for (int beat = 0; beat < 4; beat++) begin
         set_r(1, 0, 32'hA0 + beat, beat == 3);
         #1;
         chk("rd_r_vld", gr_v, 1);
         chk("rd_r_dst", gr.dst, 3);
         chk("rd_r_src", gr.src, 9);
         chk("rd_r_id", gr.payload.id, 5);
         chk("rd_r_data", gr.payload.data, 32'hA0 + beat);
         chk("rd_r_rdy", req.r_ready, 1);
         step();
      end
      set_r(0, 0, 0, 0);

      // Slot 0 freed by rlast; refill the whole read table.
      set_ar(1, 2, 1, 0);
      #1;
      chk("rd_reuse_id", req.ar.id, 0);
      step();
      for (int k = 1; k < 8; k++) begin
         set_ar(1, 4'(k), 4'(15 - k), 0);
         #1;
         chk("full_fill_id", req.ar.id, k);
         step();
      end
      set_ar(1, 8, 0, 0);
      #1;
      chk("full_ar_rdy", gar_r, 0);
      chk("full_ar_vld", req.ar_valid, 0);
      set_r(1, 6, 32'h66, 1);
      #1;
      chk("full_r_dst", gr.dst, 6);
      chk("full_r_id", gr.payload.id, 9);
      chk("full_same_cyc_rdy", gar_r, 0);
      step();
      set_r(0, 0, 0, 0);
      #1;
      chk("freed_ar_rdy", gar_r, 1);
      chk("freed_ar_id", req.ar.id, 6);
      step();
      set_ar(0, 0, 0, 0);
      #1;
      chk("refull_ar_rdy", gar_r, 0);

      // B on a never-allocated write slot is sunk with an error pulse.
      set_b(1, 7);
      #1;
      chk("inv_b_rdy", req.b_ready, 1);
      chk("inv_b_vld", gb_v, 0);
      chk("inv_err", err, 1);
      step();
      set_b(0, 0);
      #1;
      chk("inv_err_clr", err, 0);

      // Two sources reuse AXI id 2; B returns out of order.
      set_aw(1, 1, 2);
      #1;
      chk("col_aw_id0", req.aw.id, 0);
      chk("col_aw_rdy", gaw_r, 1);
      step();
      set_aw(1, 4, 2);
      set_w(1, 1, 32'h11, 1);
      #1;
      chk("col_aw_blocked", gaw_r, 0);
      chk("col_w_vld", req.w_valid, 1);
      chk("col_w_rdy", gw_r, 1);
      step();
      set_w(0, 0, 0, 0);
      #1;
      chk("col_aw_id1", req.aw.id, 1);
      chk("col_aw_rdy1", gaw_r, 1);
      step();
      set_aw(0, 0, 0);
      set_w(1, 4, 32'h44, 1);
      #1;
      chk("col_w2_rdy", gw_r, 1);
      step();
      set_w(0, 0, 0, 0);
      set_b(1, 1);
      #1;
      chk("col_b1_vld", gb_v, 1);
      chk("col_b1_dst", gb.dst, 4);
      chk("col_b1_id", gb.payload.id, 2);
      chk("col_b1_src", gb.src, 9);
      step();
      set_b(1, 0);
      #1;
      chk("col_b0_dst", gb.dst, 1);
      chk("col_b0_id", gb.payload.id, 2);
      step();
      set_b(0, 0);

      // Write source lock: src=2 data waits for src=1 burst and its own AW.
      set_aw(1, 1, 3);
      #1;
      chk("lock_aw_id", req.aw.id, 0);
      step();
      set_aw(0, 0, 0);
      set_w(1, 2, 32'h22, 0);
      #1;
      chk("lock_w_rdy", gw_r, 0);
      chk("lock_w_vld", req.w_valid, 0);
      step();
      chk("lock_w_rdy_held", gw_r, 0);
      set_w(1, 1, 32'h10, 0);
      #1;
      chk("lock_own_rdy", gw_r, 1);
      step();
      set_w(1, 1, 32'h12, 1);
      #1;
      chk("lock_own_last_rdy", gw_r, 1);
      step();
      set_w(1, 2, 32'h22, 0);
      #1;
      chk("lock_idle_rdy", gw_r, 0);
      chk("lock_idle_vld", req.w_valid, 0);
      set_aw(1, 2, 7);
      #1;
      chk("lock_aw2_id", req.aw.id, 1);
      chk("lock_aw2_w_rdy", gw_r, 0);
      step();
      set_aw(0, 0, 0);
      #1;
      chk("lock_w2_rdy", gw_r, 1);
      chk("lock_w2_vld", req.w_valid, 1);
      step();

      // Reset in the middle of the src=2 burst.
      srst = 1'b1;
      #1;
      chk("srst_w_vld", req.w_valid, 0);
      step();
      srst = 1'b0;
      #1;
      chk("post_rst_w_vld", req.w_valid, 0);
      chk("post_rst_w_rdy", gw_r, 0);
      chk("post_rst_aw_vld", req.aw_valid, 0);
      chk("post_rst_b_vld", gb_v, 0);
      chk("post_rst_r_vld", gr_v, 0);
      chk("post_rst_err", err, 0);
      set_ar(1, 5, 4, 0);
      set_aw(1, 3, 1);
      #1;
      chk("fresh_ar_rdy", gar_r, 1);
      chk("fresh_ar_id", req.ar.id, 0);
      chk("fresh_aw_rdy", gaw_r, 1);
      chk("fresh_aw_id", req.aw.id, 0);
      step();
      set_ar(0, 0, 0, 0); set_aw(0, 0, 0); set_w(0, 0, 0, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axi_grid_mni.md
# axi_grid_mni

Manager network interface for the AXI grid NoC: the exit point of a grid node toward a local AXI subordinate. It receives AW/W/AR request flits from the grid, reissues them as AXI requests with locally allocated IDs, and returns B/R responses to the originating node with the original ID restored. It is the counterpart of `axi_grid_sni`, which injects manager traffic into the grid.

## Interface
- `req_t`: default `axi_default_param_pkg::mni_req_t`; AXI request bundle driven to the subordinate.
- `resp_t`: default `axi_default_param_pkg::mni_resp_t`; AXI response bundle from the subordinate.
- `grid_id_t`, `grid_aw_chan_t`, `grid_w_chan_t`, `grid_b_chan_t`, `grid_ar_chan_t`, `grid_r_chan_t`: defaults from `axi_default_param_pkg`; each grid flit carries `src`, `dst` and an AXI payload.
- `NI_ID`: default `'0`; this node's grid ID, placed in `src` of every outgoing B/R flit.
- `MAX_W_TXN`: default 8; number of outstanding writes. Must be ≤ 2^(AXI ID width).
- `MAX_R_TXN`: default 8; number of outstanding reads. Same limit as `MAX_W_TXN`.
- `clk_i` input, 1 bit: the single clock.
- `srst_i` input, 1 bit: reset, synchronous to `clk_i`, active-high.
- `req_o` output, `req_t`: AXI request to the subordinate.
- `resp_i` input, `resp_t`: AXI response from the subordinate.
- `grid_aw_i` / `grid_w_i` / `grid_ar_i` inputs, chan types: request flits from the grid. Each has a `_valid_i` input and a `_ready_o` output.
- `grid_b_o` / `grid_r_o` outputs, chan types: response flits to the grid. Each has a `_valid_o` output and a `_ready_i` input.
- `err_o` output, 1 bit: one-cycle pulse when a response arrives with an ID whose table slot is not valid.

## Operation
- **Write transaction table** (`MAX_W_TXN` entries) and **read transaction table** (`MAX_R_TXN` entries).
  - Each entry holds `{valid, src node, original AXI id}`.
  - Allocation picks the lowest free index.
  - The entry index becomes the AXI ID on `req_o`; the upper ID bits are zero.
- **AR path.** An AR flit is accepted when a read slot is free and `ar_ready` is high. On acceptance: the AR is forwarded with `id` = slot index, and the slot is filled.
- **Write path state machine.**
  - `W_IDLE`: accept an AW when a write slot is free and `aw_ready` is high. Forward the AW with `id` = slot index, latch its `src` into `w_src_q`, then go to `W_DATA`.
  - `W_DATA`: accept W flits only when `src == w_src_q`; these pass to the subordinate with handshake through. On the accepted beat with `wlast` set, go to `W_IDLE`.
  - W flits from any other source stall, with `grid_w_ready_o` = 0.
- **B path.** Look up `resp_i.b.id`. Drive `grid_b_o` with `dst` = entry src, `src` = `NI_ID`, `id` = original id. On the B handshake the slot is freed.
- **R path.** Same lookup for every beat. The slot is freed on the handshake of the beat with `rlast` set.
- **Invalid slot on a response.** Assert `b_ready`/`r_ready`, drop the beat, pulse `err_o`, and leave the tables unchanged.
- **Full table.** The matching grid ready is 0. Other channels are unaffected.
- **Simultaneous free and allocate.** Allocation uses the registered free vector, so a slot freed in cycle N is allocatable at N+1 at the earliest. Allocation and a free of different slots in the same cycle both take effect.
- **Reset.** Applies at any time, including mid-burst:
  - tables cleared, state `W_IDLE`, `w_src_q` = 0;
  - all `valid`/`ready` outputs and `err_o` low;
  - in-flight transactions are discarded, so the subordinate must be reset together with this block.

## Timing
- **Request and response latency:** zero-cycle, combinational in both directions (request flit to `req_o`, `resp_i` to B/R flit). The only state is the tables, the write state machine and `w_src_q`.
- **Handshake rules:** AXI valid/ready rules on every interface.
  - Once asserted, an output valid holds its payload stable until ready.
  - No ready depends combinationally on its own valid.
- **Throughput:** one AR and one AW/W beat per cycle. The cycle after a `wlast` beat is `W_IDLE`, so AW acceptance resumes one cycle after the last W beat.
- **Table updates:** performed at the clock edge following the handshake.
- **`err_o`:** asserted in the same cycle as the dropped handshake.

## Structure
- **`axi_default_param_pkg`:** add `mni_req_t`, `mni_resp_t`, and the flit field layout (`src`, `dst`, payload) shared with the SNI.
- **Sub-module `axi_grid_mni_txn_table`:** parameterised by `DEPTH` and entry type.
  - Ports: alloc request/grant/index, lookup index to entry/valid, free strobe/index.
  - Instantiated twice, once for writes and once for reads.
- **Top level:** holds the write state machine and the channel muxing.

## Test plan
- **Single read.** AR from src=3, id=5, len=3 → `req_o` AR id=0; four R flits with dst=3, src=`NI_ID`, id=5; slot 0 is free after `rlast`.
- **Two-source ID collision.** AWs from src=1 id=2 and src=4 id=2 → AXI ids 0 and 1. Out-of-order B for id 1 → B flit dst=4 id=2; then id 0 → dst=1 id=2.
- **Write source lock.** After an AW from src=1, a W flit from src=2 is held (ready=0) until the src=1 `wlast` beat plus one cycle, and is not forwarded before its own AW.
- **Table full.** 8 reads outstanding → `grid_ar_ready_o` = 0. Completing id 6 → the next AR gets id 6 one cycle after the `rlast` handshake.
- **Invalid response.** B with id=7 while slot 7 is invalid → `b_ready` = 1, no B flit, `err_o` high for 1 cycle.
- **Reset mid-burst.** `srst_i` asserted mid-W burst → next cycle all valids 0, state `W_IDLE`, tables empty; a fresh AR gets id 0.
